moving_average_mc: RTL and testbench
====================================

MOVING_AVERAGE_MC -- requirements
Module: moving_average_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed two's-complement sample width.
REQ-002 Parameter CHANNELS, default 4: number of independent time-interleaved channels (>=1).
REQ-003 Parameter MAX_WINDOW_LOG2, default 5: log2 of the largest window (32 samples).
REQ-004 Port clk  input  1: single clock, all logic rising-edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port input_data  input  DATA_WIDTH: signed sample.
REQ-007 Port input_channel  input  max(1,$clog2(CHANNELS)): channel index of input_data.
REQ-008 Port enable  input  1: input_data/input_channel valid this cycle.
REQ-009 Port window  input  $clog2(MAX_WINDOW_LOG2+1): log2 of active window W=2^window; values >MAX_WINDOW_LOG2 clamp to MAX_WINDOW_LOG2.
REQ-010 Port output_data  output  DATA_WIDTH: signed average.
REQ-011 Port output_channel  output  width of input_channel: channel of output_data.
REQ-012 Port output_data_valid  output  1: one-cycle strobe qualifying output_data/output_channel.
REQ-013 Port output_primed  output  1: output channel has received >=W samples since last clear.

Function
REQ-014 Each enabled sample x on channel c SHALL update acc[c] = acc[c] + x - x_old, x_old = channel c sample W samples earlier, or 0 if channel c has fewer than W samples since last clear.
REQ-015 acc SHALL be DATA_WIDTH+MAX_WINDOW_LOG2 bits signed; no overflow possible.
REQ-016 Per-channel history SHALL be a MAX_WINDOW-deep circular buffer with per-channel write pointer wrapping MAX_WINDOW-1 -> 0; x_old read at (wptr - W) mod MAX_WINDOW.
REQ-017 output_data SHALL equal updated acc[c] arithmetically shifted right by window (see REQ-026), truncated to DATA_WIDTH.
REQ-018 Latency SHALL be exactly 2 cycles: enable at edge N -> output_data_valid high after edge N+2, one cycle per enable.
REQ-019 enable every cycle SHALL be accepted, including back-to-back same channel (accumulator forwarding, no stall, no lost samples).
REQ-020 Per-channel fill counter SHALL saturate at MAX_WINDOW; output_primed = (fill after this sample >= W).
REQ-021 Any change of window value SHALL, in the cycle it is seen, clear all accumulators, fill counters and write pointers; a sample enabled in that same cycle is processed as the first sample after clear with the new W.
REQ-022 window=0 SHALL pass input through (output = x, primed on first sample).
REQ-023 Without enable, accumulators, pointers and outputs other than output_data_valid SHALL hold.

Reset
REQ-024 reset high SHALL immediately clear output_data, output_channel, output_data_valid, output_primed, all accumulators, fill counters, pointers and pipeline valids to 0; buffer contents need not clear.
REQ-025 Reset asserted mid-pipeline SHALL discard in-flight samples; no valid emitted for them after release.

Configuration
REQ-026 Macro MOVING_AVERAGE_ROUNDING_EN defined: add 2^(window-1) (window>0) before shift, round-half-up; undefined: plain arithmetic shift (floor).

Verification
REQ-027 W=4 (window=2), ch0 samples 100,100,100,100 -> outputs 25,50,75,100 at +2 cycles; output_primed 0,0,0,1.
REQ-028 window=0, ch1 input -7 -> output_data -7, output_channel 1, primed 1, 2 cycles later.
REQ-029 window=1, alternate ch0=+1000/ch1=-1000 every cycle, 4 samples each -> ch0 500,1000,1000,1000; ch1 -500,-1000,-1000,-1000; no cross-talk.
REQ-030 Steady ch0=100 at window=2, switch window to 1 with sample 100 same cycle -> output 50 primed 0, next 100 primed 1.
REQ-031 window=1, single sample -1: without macro -> -1; with MOVING_AVERAGE_ROUNDING_EN -> 0; window=2 samples 1,1 -> 0 vs 1.
REQ-032 Assert reset with 2 samples in flight -> valid drops same cycle, no stale output; after release, window=2 sample 8 -> output 2, primed 0.

Source files
------------

// File: rtl/moving_average_mc.sv
// rtl/moving_average_mc.sv - time-interleaved multi-channel moving average over 2^window samples
// Define MOVING_AVERAGE_ROUNDING_EN for round-half-up averaging instead of floor.
module moving_average_mc #(
  parameter int DATA_WIDTH      = 16,
  parameter int CHANNELS        = 4,
  parameter int MAX_WINDOW_LOG2 = 5,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int WW = $clog2(MAX_WINDOW_LOG2 + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic [CW-1:0]         input_channel,
  input  logic                  enable,
  input  logic [WW-1:0]         window,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic [CW-1:0]         output_channel,
  output logic                  output_data_valid,
  output logic                  output_primed
);

  localparam int L  = MAX_WINDOW_LOG2;
  localparam int MW = 1 << L;
  localparam int AW = DATA_WIDTH + L;
  localparam int FW = L + 1;

  logic [WW-1:0]                win_c, cur_win;
  logic                         clear;
  logic [L-1:0]                 wptr [CHANNELS];
  logic [FW-1:0]                fill [CHANNELS];
  logic signed [AW-1:0]         acc  [CHANNELS];
  logic signed [DATA_WIDTH-1:0] hist [CHANNELS*MW];

  logic [FW-1:0]                eff_fill, new_fill, w_fill;
  logic [L-1:0]                 eff_wptr, w_span;
  logic [CW+L-1:0]              rd_idx, wr_idx;
  logic signed [DATA_WIDTH-1:0] x_old;

  logic                         s1_valid, s1_primed;
  logic signed [DATA_WIDTH-1:0] s1_data, s1_old;
  logic [CW-1:0]                s1_ch;
  logic [WW-1:0]                s1_win;

  logic                         s2_valid, s2_primed;
  logic [DATA_WIDTH-1:0]        s2_data;
  logic [CW-1:0]                s2_ch;

  logic signed [AW-1:0]         ext_data, ext_old, acc_sum, rnd, rounded;
  logic [DATA_WIDTH-1:0]        avg;

  // A window change wipes channel state in the same cycle, so the incoming sample sees an empty history.
  always_comb begin
    win_c    = (window > WW'(L)) ? WW'(L) : window;
    clear    = (win_c != cur_win);
    eff_fill = clear ? '0 : fill[input_channel];
    eff_wptr = clear ? '0 : wptr[input_channel];
    w_span   = L'(1) << win_c;
    w_fill   = FW'(1) << win_c;
    wr_idx   = {input_channel, eff_wptr};
    rd_idx   = {input_channel, eff_wptr - w_span};
    x_old    = (eff_fill >= w_fill) ? hist[rd_idx] : '0;
    new_fill = (eff_fill == FW'(MW)) ? eff_fill : eff_fill + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (enable) hist[wr_idx] <= input_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_win   <= '0;
      s1_valid  <= 1'b0;
      s1_primed <= 1'b0;
      s1_data   <= '0;
      s1_old    <= '0;
      s1_ch     <= '0;
      s1_win    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        fill[c] <= '0;
      end
    end else begin
      cur_win  <= win_c;
      s1_valid <= enable;
      if (clear) begin
        for (int c = 0; c < CHANNELS; c++) begin
          wptr[c] <= '0;
          fill[c] <= '0;
        end
      end
      if (enable) begin
        wptr[input_channel] <= eff_wptr + L'(1);
        fill[input_channel] <= new_fill;
        s1_data             <= input_data;
        s1_old              <= x_old;
        s1_ch               <= input_channel;
        s1_win              <= win_c;
        s1_primed           <= (new_fill >= w_fill);
      end
    end
  end

  // Single-cycle read-modify-write of acc keeps back-to-back same-channel samples coherent.
  always_comb begin
    ext_data = {{L{s1_data[DATA_WIDTH-1]}}, s1_data};
    ext_old  = {{L{s1_old[DATA_WIDTH-1]}}, s1_old};
    acc_sum  = acc[s1_ch] + ext_data - ext_old;
`ifdef MOVING_AVERAGE_ROUNDING_EN
    rnd      = (s1_win != '0) ? (AW'(1) << (s1_win - WW'(1))) : '0;
`else
    rnd      = '0;
`endif
    rounded  = acc_sum + rnd;
    avg      = DATA_WIDTH'(rounded >>> s1_win);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_primed <= 1'b0;
      s2_data   <= '0;
      s2_ch     <= '0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (clear) begin
        for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
      end else if (s1_valid) begin
        acc[s1_ch] <= acc_sum;
      end
      if (s1_valid) begin
        s2_data   <= avg;
        s2_ch     <= s1_ch;
        s2_primed <= s1_primed;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_data_valid <= 1'b0;
      output_data       <= '0;
      output_channel    <= '0;
      output_primed     <= 1'b0;
    end else begin
      output_data_valid <= s2_valid;
      if (s2_valid) begin
        output_data    <= s2_data;
        output_channel <= s2_ch;
        output_primed  <= s2_primed;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_mc.sv
// tb/tb_moving_average_mc.sv - randomized and directed check of moving_average_mc against a queue-based model
// Honours MOVING_AVERAGE_ROUNDING_EN the same way as the design.
module tb_moving_average_mc;

  localparam int DW = 16;
  localparam int CH = 4;
  localparam int ML = 5;
  localparam int MW = 32;
  localparam int CW = 2;
  localparam int WW = 3;
`ifdef MOVING_AVERAGE_ROUNDING_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] input_data = '0;
  logic [CW-1:0] input_channel = '0;
  logic          enable = 1'b0;
  logic [WW-1:0] window = '0;
  logic [DW-1:0] output_data;
  logic [CW-1:0] output_channel;
  logic          output_data_valid;
  logic          output_primed;

  moving_average_mc dut (
    .clk(clk), .reset(reset), .input_data(input_data), .input_channel(input_channel),
    .enable(enable), .window(window), .output_data(output_data),
    .output_channel(output_channel), .output_data_valid(output_data_valid),
    .output_primed(output_primed)
  );

  always #5 clk = ~clk;

  typedef struct { longint due; longint data; int ch; bit primed; } exp_t;
  typedef struct { longint data; bit primed; } lit_t;

  exp_t   sb [$];
  lit_t   lit [$];
  longint hist [CH][$];
  int     mwin = 0;
  int     drv_w = 0;
  longint cyc = 0;
  longint last_data = 0;
  int     last_ch = 0;
  bit     last_primed = 1'b0;
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic pin(input longint d, input bit p);
    lit_t l;
    l.data = d;
    l.primed = p;
    lit.push_back(l);
  endtask

  task automatic model_clear();
    sb.delete();
    lit.delete();
    for (int c = 0; c < CH; c++) hist[c].delete();
    mwin = 0;
    last_data = 0;
    last_ch = 0;
    last_primed = 1'b0;
  endtask

  task automatic observe();
    exp_t e;
    lit_t l;
    bit   ev;
    while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
    ev = (sb.size() > 0) && (sb[0].due == cyc);
    check("valid", output_data_valid, ev);
    if (ev) begin
      e = sb.pop_front();
      check("data", $signed(output_data), e.data);
      check("channel", output_channel, e.ch);
      check("primed", output_primed, e.primed);
      last_data = e.data;
      last_ch = e.ch;
      last_primed = e.primed;
      if (lit.size() > 0) begin
        l = lit.pop_front();
        check("lit_data", $signed(output_data), l.data);
        check("lit_primed", output_primed, l.primed);
      end
    end else if (!output_data_valid) begin
      check("hold_data", $signed(output_data), last_data);
      check("hold_channel", output_channel, last_ch);
      check("hold_primed", output_primed, last_primed);
    end
  endtask

  // Model: average of the last W samples of the channel since the last clear, absent ones taken as zero.
  task automatic drive(input bit en, input int ch, input longint x, input int w);
    exp_t   e;
    int     wc, ww, n;
    longint sum;
    drv_w = w;
    enable = en;
    input_channel = ch[CW-1:0];
    input_data = x[DW-1:0];
    window = w[WW-1:0];
    wc = (w > ML) ? ML : w;
    if (wc != mwin) begin
      for (int c = 0; c < CH; c++) hist[c].delete();
      mwin = wc;
    end
    if (en) begin
      hist[ch].push_back(x);
      if (hist[ch].size() > MW) void'(hist[ch].pop_front());
      ww = 1 << wc;
      n = hist[ch].size();
      sum = 0;
      for (int i = (n > ww) ? n - ww : 0; i < n; i++) sum += hist[ch][i];
      if (RND && wc > 0) sum += ww / 2;
      e.due = cyc + 3;
      e.data = sum >>> wc;
      e.ch = ch;
      e.primed = (n >= ww);
      sb.push_back(e);
    end
    tick();
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, drv_w);
  endtask

  task automatic check_reset_state();
    check("rst_valid", output_data_valid, 0);
    check("rst_data", output_data, 0);
    check("rst_channel", output_channel, 0);
    check("rst_primed", output_primed, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_state();
    model_clear();
    enable = 1'b0;
    window = '0;
    drv_w = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    check_reset_state();
    reset = 1'b0;

    drive(1'b0, 0, 0, 2);
    pin(25, 0); pin(50, 0); pin(75, 0); pin(100, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, 0, 100, 2);
    idle(3);

    pin(-7, 1);
    drive(1'b1, 1, -7, 0);
    idle(3);

    pin(500, 0); pin(-500, 0);
    for (int i = 0; i < 3; i++) begin pin(1000, 1); pin(-1000, 1); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 0, 1000, 1);
      drive(1'b1, 1, -1000, 1);
    end
    idle(3);

    pin(25, 0); pin(50, 0); pin(75, 0); pin(100, 1); pin(50, 0); pin(100, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, 0, 100, 2);
    drive(1'b1, 0, 100, 1);
    drive(1'b1, 0, 100, 1);
    idle(3);

    pin(RND ? 0 : -1, 0);
    drive(1'b1, 2, -1, 1);
    idle(3);
    pin(0, 0); pin(RND ? 1 : 0, 0);
    drive(1'b1, 3, 1, 2);
    drive(1'b1, 3, 1, 2);
    idle(3);

    drive(1'b1, 0, 5, 2);
    drive(1'b1, 0, 6, 2);
    do_reset();
    pin(2, 0);
    drive(1'b1, 0, 8, 2);
    idle(3);

    for (int i = 0; i < 80; i++)
      drive(1'b1, 1, longint'($urandom_range(65535)) - 32768, 5);

    begin
      int w;
      w = 2;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(39) == 0) w = $urandom_range(7);
        drive($urandom_range(3) != 0, $urandom_range(CH - 1),
              longint'($urandom_range(65535)) - 32768, w);
      end
    end
    idle(4);
    check("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
